// File: rtl/accumulator_weight_ctrl_pkg.sv
// accumulator_weight_ctrl_pkg: shared states, sizing and the accumulator width check for the weight-accumulator sequencer.
package accumulator_weight_ctrl_pkg;
  localparam int MAX_LEN = 256;
  localparam int CNT_WIDTH = $clog2(MAX_LEN + 1);
  localparam int WEIGHT_WIDTH = 8;
  localparam int ACC_WIDTH = 16;
  localparam bit ACC_WIDTH_OK = ACC_WIDTH >= WEIGHT_WIDTH + $clog2(MAX_LEN);
  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, HOLD} state_e;
  typedef logic [CNT_WIDTH-1:0] cnt_t;
  function automatic cnt_t sat_len(input cnt_t l);
    return (l > cnt_t'(MAX_LEN)) ? cnt_t'(MAX_LEN) : l;
  endfunction
endpackage

// File: rtl/accumulator_weight_ctrl_beat_counter.sv
// accumulator_weight_ctrl_beat_counter: beat up-counter with sync clear, enable and terminal match against the job length.
module accumulator_weight_ctrl_beat_counter
  import accumulator_weight_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 last_o
);
  cnt_t cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + cnt_t'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
  assign last_o = en_i & (cnt_q == len_i - cnt_t'(1));
endmodule

// File: rtl/accumulator_weight_ctrl.sv
// accumulator_weight_ctrl: clears the accumulator, streams LEN weight beats into it, then holds the result until taken.
module accumulator_weight_ctrl
  import accumulator_weight_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] len,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 acc_enable,
  output logic                 acc_clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] beat_cnt
);
  state_e state_q, state_d;
  cnt_t len_q, len_d;
  logic launch, last;
  if (!ACC_WIDTH_OK) begin : g_width_chk
    $error("ACC_WIDTH too narrow for WEIGHT_WIDTH + clog2(MAX_LEN)");
  end
  assign launch = (state_q == IDLE) & start & ~abort;
  assign in_ready = state_q == ACCUM;
  assign acc_enable = in_valid & in_ready & ~abort;
  // gated by rst_n so an abort held during reset cannot wipe the accumulator
  assign acc_clear = rst_n & ((state_q == CLEAR) | abort);
  assign out_valid = state_q == HOLD;
  assign busy = state_q != IDLE;
  assign done = out_valid & out_ready & ~abort;
  always_comb begin
    len_d = launch ? sat_len(len) : len_q;
    state_d = abort ? IDLE :
              (state_q == IDLE)  ? (start ? CLEAR : IDLE) :
              (state_q == CLEAR) ? ((len_q == '0) ? HOLD : ACCUM) :
              (state_q == ACCUM) ? (last ? HOLD : ACCUM) :
              (out_ready ? IDLE : HOLD);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      len_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
    end
  accumulator_weight_ctrl_beat_counter u_beat_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (launch | abort),
    .en_i   (acc_enable),
    .len_i  (len_q),
    .cnt_o  (beat_cnt),
    .last_o (last)
  );
endmodule

// File: tb/tb_accumulator_weight_ctrl.sv
// tb_accumulator_weight_ctrl: table vectors, directed corner sequences and random stimulus against a count-based job model.
module tb_accumulator_weight_ctrl;
  logic clk = 1'b0;
  logic rst_n, start, abort, in_valid, out_ready;
  logic [8:0] len;
  logic in_ready, acc_enable, acc_clear, out_valid, busy, done;
  logic [8:0] beat_cnt;
  int n_chk = 0, n_fail = 0, n_done = 0, n_ov = 0;
  int acc_sum, acc_k;
  bit m_job, m_clr;
  int m_got, m_len;

  accumulator_weight_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .acc_enable(acc_enable),
    .acc_clear(acc_clear), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  // accumulator stand-in: the k-th accepted weight of a job has value k
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin acc_sum <= 0; acc_k <= 0; end
    else if (acc_clear) begin acc_sum <= 0; acc_k <= 0; end
    else if (acc_enable) begin acc_sum <= acc_sum + acc_k + 1; acc_k <= acc_k + 1; end

  typedef struct {
    logic       s;
    logic [8:0] l;
    logic       ab, iv, ordy;
    logic [5:0] flags;
    logic [8:0] beat;
    int         sum;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [31:0] outs();
    return {17'b0, in_ready, acc_enable, acc_clear, out_valid, busy, done, beat_cnt};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic [8:0] l, input logic ab, iv, ordy);
    start = s; len = l; abort = ab; in_valid = iv; out_ready = ordy;
  endtask

  task automatic step(input logic s, input logic [8:0] l, input logic ab, iv, ordy);
    bit ir, ov;
    drive(s, l, ab, iv, ordy);
    @(negedge clk);
    ir = m_job && !m_clr && m_got < m_len;
    ov = m_job && !m_clr && m_got == m_len;
    check("step_outputs", outs(),
          {17'b0, ir, ir & iv & ~ab, m_clr | ab, ov, m_job, ov & ordy & ~ab, 9'(m_got)});
    if (ov) check("step_sum", acc_sum, m_got * (m_got + 1) / 2);
    if (done) n_done++;
    if (out_valid) n_ov++;
    if (ab) begin m_job = 0; m_clr = 0; m_got = 0; end
    else if (!m_job) begin
      if (s) begin m_job = 1; m_clr = 1; m_got = 0; m_len = (int'(l) > 256) ? 256 : int'(l); end
    end
    else if (m_clr) m_clr = 0;
    else if (ir && iv) m_got++;
    else if (ov && ordy) m_job = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    m_job = 0; m_clr = 0; m_got = 0; m_len = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", outs(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // flags: {in_ready, acc_enable, acc_clear, out_valid, busy, done}
    tbl.push_back('{1, 4, 0, 1, 0, 6'b000000, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 6'b001010, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 6'b110010, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 6'b110010, 1, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 6'b110010, 2, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 6'b110010, 3, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 6'b000110, 4, 10});
    tbl.push_back('{0, 0, 0, 0, 1, 6'b000111, 4, 10});
    tbl.push_back('{0, 0, 0, 0, 0, 6'b000000, 4, 0});
    tbl.push_back('{1, 3, 0, 0, 0, 6'b000000, 4, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 6'b001010, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 6'b110010, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 6'b100010, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 6'b100010, 1, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 6'b110010, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 6'b100010, 2, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 6'b110010, 2, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 6'b000111, 3, 6});
    tbl.push_back('{0, 0, 0, 0, 0, 6'b000000, 3, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 6'b000000, 3, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 6'b001010, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 6'b000111, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 6'b000000, 0, 0});
    tbl.push_back('{1, 5, 1, 0, 0, 6'b001000, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 6'b000000, 0, 0});
    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].l, tbl[i].ab, tbl[i].iv, tbl[i].ordy);
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(), {17'b0, tbl[i].flags, tbl[i].beat});
      if (tbl[i].flags[2]) check($sformatf("vec%0d_sum", i), acc_sum, tbl[i].sum);
      @(posedge clk); #1;
    end
    // consumer stall with start pulses during HOLD
    step(1, 2, 0, 0, 0); step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);
    n_done = 0; n_ov = 0;
    repeat (5) step(1, 7, 0, 1, 0);
    step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 0);
    check("stall_done_count", n_done, 1);
    check("stall_ov_cycles", n_ov, 6);
    // abort after 2 of 5 beats
    n_done = 0;
    step(1, 5, 0, 0, 0); step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 1); step(0, 0, 0, 0, 1);
    check("abort_sum", acc_sum, 0);
    check("abort_no_done", n_done, 0);
    // asynchronous reset mid-ACCUM
    step(1, 5, 0, 0, 0); step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1);
    #3 rst_n = 1'b0;
    #1 check("async_reset_outputs", outs(), 0);
    m_job = 0; m_clr = 0; m_got = 0; m_len = 0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    n_done = 0;
    step(1, 1, 0, 0, 0); step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 0);
    check("post_reset_done", n_done, 1);
    // random traffic including oversize lengths that saturate
    repeat (3000)
      step($urandom_range(0, 2) == 0,
           ($urandom_range(0, 19) == 0) ? 9'($urandom_range(250, 300)) : 9'($urandom_range(0, 6)),
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
